// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register index width, the hardwired zero
// register index and the MEM/WB writeback source encodings.
package pipeline_pkg;

   // Architectural register file geometry
   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 1 << REG_IDX_W;

   // Index of the hardwired-zero register
   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

   // Writeback source select carried in MEM/WB
   localparam logic [1:0] MTR_ALU  = 2'b00;
   localparam logic [1:0] MTR_MEM  = 2'b01;
   localparam logic [1:0] MTR_LINK = 2'b10;
   localparam logic [1:0] MTR_RSVD = 2'b11;

   // True when a write enable and destination index form a real
   // architectural write (writes aimed at $0 are discarded).
   function automatic logic arch_write(input logic                 reg_write,
                                       input logic [REG_IDX_W-1:0] reg_dest);
      return reg_write && (reg_dest != REG_ZERO);
   endfunction

endpackage : pipeline_pkg

// File: rtl/regfile_2r1w.sv
// Architectural register file: one write port, two combinational read
// ports with same-cycle write-to-read bypass, $0 hardwired to zero and an
// asynchronous active-low clear of the whole array.
module regfile_2r1w
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  WriteEnable,
   input  logic [REG_IDX_W-1:0]  WriteAddr,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [REG_IDX_W-1:0]  ReadAddr1,
   input  logic [REG_IDX_W-1:0]  ReadAddr2,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2
);

   localparam int NUM_PORTS = 2;

   // Storage. Entry 0 exists only so every 5-bit index is in range; it is
   // never written, and the read ports force it to zero anyway.
   logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

   // Write qualification repeated here so the array can never be corrupted
   // at $0 regardless of what the caller presents.
   logic write_en;
   assign write_en = arch_write(WriteEnable, WriteAddr);

   // Array update: async clear of every entry, otherwise commit the
   // addressed register on a qualified write.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (write_en) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (WriteAddr == REG_IDX_W'(i)) begin
               regs_reg[i] <= WriteData;
            end
         end
      end
   end

   // Read ports share one description; each port resolves its own index.
   logic [REG_IDX_W-1:0]  rd_addr [NUM_PORTS];
   logic [DATA_WIDTH-1:0] rd_data [NUM_PORTS];

   assign rd_addr[0] = ReadAddr1;
   assign rd_addr[1] = ReadAddr2;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_read_port
         logic [DATA_WIDTH-1:0] port_data;

         // Priority: $0 reads zero, then the in-flight write wins over the
         // stored copy so ID never sees the stale value.
         always_comb begin
            port_data = regs_reg[rd_addr[gi]];
            if (rd_addr[gi] == REG_ZERO) begin
               port_data = '0;
            end else if (write_en && (rd_addr[gi] == WriteAddr)) begin
               port_data = WriteData;
            end
         end

         assign rd_data[gi] = port_data;
      end
   endgenerate

   assign ReadData1 = rd_data[0];
   assign ReadData2 = rd_data[1];

endmodule : regfile_2r1w

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the writeback value from MEM/WB, commits it to
// the architectural register file, serves the ID read ports and counts
// retired architectural writes.
module writeback_regfile
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  RegWrite_In,
   input  logic [1:0]            MemToReg_In,
   input  logic [REG_IDX_W-1:0]  RegDest_In,
   input  logic [DATA_WIDTH-1:0] ALUResult_In,
   input  logic [DATA_WIDTH-1:0] PCI_In,
   input  logic [DATA_WIDTH-1:0] ReadData_In,
   input  logic [REG_IDX_W-1:0]  ReadReg1_In,
   input  logic [REG_IDX_W-1:0]  ReadReg2_In,
   output logic [DATA_WIDTH-1:0] ReadData1_Out,
   output logic [DATA_WIDTH-1:0] ReadData2_Out,
   output logic [DATA_WIDTH-1:0] WriteData_Out,
   output logic                  WriteValid_Out,
   output logic [CNT_WIDTH-1:0]  RetireCount_Out
);

   logic [DATA_WIDTH-1:0] write_data;
   logic                  write_valid;
   logic [CNT_WIDTH-1:0]  retire_count_reg;
   logic [CNT_WIDTH-1:0]  retire_count_next;

   // Writeback source mux; the reserved encoding falls back to the ALU.
   always_comb begin
      write_data = ALUResult_In;
      case (MemToReg_In)
         MTR_ALU:  write_data = ALUResult_In;
         MTR_MEM:  write_data = ReadData_In;
         MTR_LINK: write_data = PCI_In;
         default:  write_data = ALUResult_In;
      endcase
   end

   // A bubble or a write aimed at $0 is not an architectural write.
   assign write_valid = arch_write(RegWrite_In, RegDest_In);

   // Free-running wrap on overflow; a stalled write is counted each cycle
   // it is presented, which is the pipeline controller's concern.
   assign retire_count_next = retire_count_reg + CNT_WIDTH'(1);

   // Retire counter: async clear, advance once per qualified write edge.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         retire_count_reg <= '0;
      end else if (write_valid) begin
         retire_count_reg <= retire_count_next;
      end
   end

   regfile_2r1w #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_regfile (
      .Clock       (Clock),
      .Reset       (Reset),
      .WriteEnable (RegWrite_In),
      .WriteAddr   (RegDest_In),
      .WriteData   (write_data),
      .ReadAddr1   (ReadReg1_In),
      .ReadAddr2   (ReadReg2_In),
      .ReadData1   (ReadData1_Out),
      .ReadData2   (ReadData2_Out)
   );

   assign WriteData_Out   = write_data;
   assign WriteValid_Out  = write_valid;
   assign RetireCount_Out = retire_count_reg;

endmodule : writeback_regfile

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed steps followed by a
// randomized run, all checked against an array-based register file model.
// A second instance with a 4-bit counter exercises the wrap behaviour.
module tb_writeback_regfile;

   logic        Clock;
   logic        Reset;
   logic        RegWrite;
   logic [1:0]  MemToReg;
   logic [4:0]  RegDest;
   logic [31:0] ALUResult;
   logic [31:0] PCI;
   logic [31:0] LoadData;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;

   logic [31:0] rd1, rd2, wd;
   logic        wv;
   logic [31:0] cnt;
   logic [31:0] rd1_4, rd2_4, wd_4;
   logic        wv_4;
   logic [3:0]  cnt_4;

   writeback_regfile #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .RegWrite_In     (RegWrite),
      .MemToReg_In     (MemToReg),
      .RegDest_In      (RegDest),
      .ALUResult_In    (ALUResult),
      .PCI_In          (PCI),
      .ReadData_In     (LoadData),
      .ReadReg1_In     (ReadReg1),
      .ReadReg2_In     (ReadReg2),
      .ReadData1_Out   (rd1),
      .ReadData2_Out   (rd2),
      .WriteData_Out   (wd),
      .WriteValid_Out  (wv),
      .RetireCount_Out (cnt)
   );

   writeback_regfile #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
      .Clock           (Clock),
      .Reset           (Reset),
      .RegWrite_In     (RegWrite),
      .MemToReg_In     (MemToReg),
      .RegDest_In      (RegDest),
      .ALUResult_In    (ALUResult),
      .PCI_In          (PCI),
      .ReadData_In     (LoadData),
      .ReadReg1_In     (ReadReg1),
      .ReadReg2_In     (ReadReg2),
      .ReadData1_Out   (rd1_4),
      .ReadData2_Out   (rd2_4),
      .WriteData_Out   (wd_4),
      .WriteValid_Out  (wv_4),
      .RetireCount_Out (cnt_4)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Reference model
   logic [31:0] m_regs [32];
   logic [31:0] m_count;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] exp_wd();
      if (MemToReg == 2'd1) return LoadData;
      if (MemToReg == 2'd2) return PCI;
      return ALUResult;
   endfunction

   function automatic logic exp_wv();
      return RegWrite && (RegDest != 5'd0);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (exp_wv() && idx == RegDest) return exp_wd();
      return m_regs[idx];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 32'd0;
   endtask

   // Combinational checks on the currently driven inputs
   task automatic check_comb();
      check("wdata",  wd, exp_wd());
      check("wvalid", {31'd0, wv}, {31'd0, exp_wv()});
      check("read1",  rd1, exp_read(ReadReg1));
      check("read2",  rd2, exp_read(ReadReg2));
   endtask

   task automatic check_counts();
      check("count",   cnt, m_count);
      check("count4",  {28'd0, cnt_4}, m_count & 32'hF);
   endtask

   // One pipeline cycle: drive, check combinational view, clock, update
   // the model, check the counters.
   task automatic step(input logic rw, input logic [1:0] mtr, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pci,
                       input logic [4:0] r1, input logic [4:0] r2);
      RegWrite = rw; MemToReg = mtr; RegDest = dest;
      ALUResult = alu; LoadData = mem; PCI = pci;
      ReadReg1 = r1; ReadReg2 = r2;
      #1;
      check_comb();
      @(posedge Clock);
      if (Reset && rw && dest != 5'd0) begin
         m_regs[dest] = exp_wd();
         m_count      = m_count + 32'd1;
      end
      #1;
      check_counts();
   endtask

   task automatic read_pair(input logic [4:0] r1, input logic [4:0] r2);
      ReadReg1 = r1; ReadReg2 = r2;
      #1;
      check("read1", rd1, exp_read(r1));
      check("read2", rd2, exp_read(r2));
   endtask

   initial begin
      logic [4:0] d;
      Reset = 1'b0; RegWrite = 1'b0; MemToReg = 2'd0; RegDest = 5'd0;
      ALUResult = 32'd0; PCI = 32'd0; LoadData = 32'd0;
      ReadReg1 = 5'd0; ReadReg2 = 5'd0;
      model_reset();

      // Reset, release, every register reads zero
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i));
      check_counts();

      // Load into r5 with bypass read in the same cycle, then stored read
      @(negedge Clock);
      step(1'b1, 2'b01, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0);
      check("r5_bypass_count", cnt, 32'd1);
      step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
      check("r5_stored", rd1, 32'hDEADBEEF);

      // Write aimed at $0 is discarded and not counted
      step(1'b1, 2'b00, 5'd0, 32'h1234, 32'h0, 32'h0, 5'd0, 5'd0);
      check("zero_wvalid", {31'd0, wv}, 32'd0);
      check("zero_count", cnt, 32'd1);

      // Writeback source sweep into r8
      for (int s = 0; s < 4; s++) begin
         step(1'b1, 2'(s), 5'd8, 32'd1, 32'd2, 32'd3, 5'd8, 5'd0);
         read_pair(5'd8, 5'd8);
      end
      step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
      check("r8_after_rsvd", rd1, 32'd1);

      // Bubble to r9: no bypass, no update
      step(1'b0, 2'b00, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd9);
      read_pair(5'd9, 5'd9);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         d = 5'($urandom_range(0, 31));
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), d,
              $urandom, $urandom, $urandom,
              ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
              ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
      end

      // 4-bit counter wrap: advance to 14, then 15 -> 0 -> 1
      for (int n = 0; n < 16 && (m_count & 32'hF) != 32'd14; n++) begin
         step(1'b1, 2'b00, 5'd1, $urandom, 32'h0, 32'h0, 5'd1, 5'd2);
      end
      step(1'b1, 2'b00, 5'd2, 32'h15, 32'h0, 32'h0, 5'd2, 5'd1);
      check("wrap_15", {28'd0, cnt_4}, 32'd15);
      step(1'b1, 2'b00, 5'd3, 32'h16, 32'h0, 32'h0, 5'd3, 5'd1);
      check("wrap_0", {28'd0, cnt_4}, 32'd0);
      step(1'b1, 2'b00, 5'd4, 32'h17, 32'h0, 32'h0, 5'd4, 5'd1);
      check("wrap_1", {28'd0, cnt_4}, 32'd1);

      // Reset mid-cycle: clears at once, bypass still live, in-flight write lost
      @(negedge Clock);
      RegWrite = 1'b1; MemToReg = 2'b00; RegDest = 5'd3; ALUResult = 32'hCAFE_0003;
      #2;
      Reset = 1'b0;
      model_reset();
      #1;
      check("rst_count", cnt, 32'd0);
      read_pair(5'd3, 5'd4);
      check("rst_bypass", rd1, 32'hCAFE_0003);
      RegWrite = 1'b0;
      for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i));
      RegWrite = 1'b1;
      @(posedge Clock);
      #1;
      check("rst_no_count", cnt, 32'd0);
      @(negedge Clock);
      RegWrite = 1'b0;
      Reset = 1'b1;
      read_pair(5'd3, 5'd4);
      check("rst_r3_lost", rd1, 32'd0);

      // First edge after release takes a write
      step(1'b1, 2'b10, 5'd31, 32'h0, 32'h0, 32'h8000_0004, 5'd31, 5'd3);
      step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd0);
      check("post_rst_r31", rd1, 32'h8000_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case the sequence above never completes
   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule : tb_writeback_regfile
